// File: rtl/apb_master_if.sv
// APB bus bundle between the apb_master bridge and its NUM_SLV peripherals.
// The master modport drives address/control; the slave modport returns PRDATA/PREADY.
interface apb_master_if #(
  parameter int unsigned NUM_SLV = 4
);
  logic [31:0]           PADDR;
  logic                  PWRITE;
  logic [31:0]           PWDATA;
  logic                  PENABLE;
  logic [NUM_SLV-1:0]    PSEL;
  logic [NUM_SLV*32-1:0] PRDATA;
  logic [NUM_SLV-1:0]    PREADY;

  modport master (
    output PADDR,
    output PWRITE,
    output PWDATA,
    output PENABLE,
    output PSEL,
    input  PRDATA,
    input  PREADY
  );

  modport slave (
    input  PADDR,
    input  PWRITE,
    input  PWDATA,
    input  PENABLE,
    input  PSEL,
    output PRDATA,
    output PREADY
  );
endinterface

// File: rtl/apb_master.sv
// apb_master: single-outstanding CPU-to-APB bridge decoding 4 KB windows onto NUM_SLV slaves.
// Optional ACCESS-phase timeout is compiled in when APB_TIMEOUT_EN is defined.
module apb_master #(
  parameter int unsigned NUM_SLV     = 4,
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic         PCLK,
  input  logic         PRESET,
  input  logic         transfer,
  input  logic         write,
  input  logic [31:0]  addr,
  input  logic [31:0]  wdata,
  output logic [31:0]  rdata,
  output logic         ready,
  output logic         err,
  apb_master_if.master apb
);

  localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [31:0]        paddr_reg;
  logic [31:0]        pwdata_reg;
  logic               pwrite_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic               mapped_reg;

  logic [NUM_SLV-1:0] psel_reg, psel_next;
  logic               penable_reg, penable_next;

  logic               done_reg, done_next;
  logic               done_err_reg, done_err_next;
  logic [31:0]        done_data_reg, done_data_next;

  logic               ready_reg;
  logic               err_reg;
  logic [31:0]        rdata_reg;

  // Address decode of the incoming request
  logic [19:0]        page;
  logic               in_range;
  logic [IDX_W-1:0]   idx_dec;

  assign page     = 20'((addr - BASE_ADDR) >> 12);
  assign in_range = (addr >= BASE_ADDR) && ({12'd0, page} < NUM_SLV);
  assign idx_dec  = page[IDX_W-1:0];

  // While IDLE the select is formed from the live request so PSEL is registered into SETUP
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_mapped;
  logic [NUM_SLV-1:0] sel_onehot;
  logic [31:0]        prdata_arr [NUM_SLV];
  logic               pready_sel;

  assign sel_idx    = (state_reg == ST_IDLE) ? idx_dec  : idx_reg;
  assign sel_mapped = (state_reg == ST_IDLE) ? in_range : mapped_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLV; gi = gi + 1) begin : g_slv
      assign sel_onehot[gi] = sel_mapped && (sel_idx == IDX_W'(gi));
      assign prdata_arr[gi] = apb.PRDATA[32*gi +: 32];
    end
  endgenerate

  assign pready_sel = apb.PREADY[idx_reg];

`ifdef APB_TIMEOUT_EN
  localparam int WAIT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT_CYC - 1);

  logic [WAIT_W-1:0] wait_cnt_reg;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      wait_cnt_reg <= '0;
    end else if (state_reg == ST_SETUP) begin
      wait_cnt_reg <= '0;
    end else if (state_reg == ST_ACCESS && !pready_sel) begin
      wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
    end
  end
`endif

  always_comb begin
    state_next     = state_reg;
    psel_next      = '0;
    penable_next   = 1'b0;
    done_next      = 1'b0;
    done_err_next  = 1'b0;
    done_data_next = '0;

    case (state_reg)
      ST_IDLE: begin
        if (transfer) begin
          state_next = ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (!mapped_reg) begin
          // Decode miss: single dummy ACCESS cycle, nothing selected
          state_next    = ST_IDLE;
          done_next     = 1'b1;
          done_err_next = 1'b1;
        end else if (pready_sel) begin
          state_next     = ST_IDLE;
          done_next      = 1'b1;
          done_data_next = pwrite_reg ? 32'd0 : prdata_arr[idx_reg];
        end
`ifdef APB_TIMEOUT_EN
        else if (wait_cnt_reg == WAIT_MAX) begin
          state_next    = ST_IDLE;
          done_next     = 1'b1;
          done_err_next = 1'b1;
        end
`endif
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    if (state_next != ST_IDLE) begin
      psel_next = sel_onehot;
    end
    penable_next = (state_next == ST_ACCESS);
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_reg     <= ST_IDLE;
      psel_reg      <= '0;
      penable_reg   <= 1'b0;
      done_reg      <= 1'b0;
      done_err_reg  <= 1'b0;
      done_data_reg <= '0;
    end else begin
      state_reg     <= state_next;
      psel_reg      <= psel_next;
      penable_reg   <= penable_next;
      done_reg      <= done_next;
      done_err_reg  <= done_err_next;
      done_data_reg <= done_data_next;
    end
  end

  // Request capture; held through SETUP/ACCESS and afterwards in IDLE
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      paddr_reg  <= '0;
      pwdata_reg <= '0;
      pwrite_reg <= 1'b0;
      idx_reg    <= '0;
      mapped_reg <= 1'b0;
    end else if (state_reg == ST_IDLE && transfer) begin
      paddr_reg  <= addr;
      pwdata_reg <= wdata;
      pwrite_reg <= write;
      idx_reg    <= idx_dec;
      mapped_reg <= in_range;
    end
  end

  // Completion is reported one edge after leaving ACCESS
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      ready_reg <= 1'b0;
      err_reg   <= 1'b0;
      rdata_reg <= '0;
    end else begin
      ready_reg <= done_reg;
      err_reg   <= done_reg & done_err_reg;
      if (done_reg) begin
        rdata_reg <= done_data_reg;
      end
    end
  end

  assign apb.PADDR   = paddr_reg;
  assign apb.PWRITE  = pwrite_reg;
  assign apb.PWDATA  = pwdata_reg;
  assign apb.PENABLE = penable_reg;
  assign apb.PSEL    = psel_reg;

  assign rdata = rdata_reg;
  assign ready = ready_reg;
  assign err   = err_reg;

endmodule

// File: tb/tb_apb_master.sv
// Randomized bench for apb_master: register-file slaves with programmable wait states,
// a reference memory/latency model feeding a scoreboard, and a per-cycle APB bus checker.
module tb_apb_master;

  localparam int          NSLV  = 4;
  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          STUCK = 1000000;
`ifdef APB_TIMEOUT_EN
  localparam int TMO    = 8;
  localparam bit TMO_EN = 1'b1;
`else
  localparam int TMO    = 255;
  localparam bit TMO_EN = 1'b0;
`endif

  logic        PCLK     = 1'b0;
  logic        PRESET   = 1'b1;
  logic        transfer = 1'b0;
  logic        write    = 1'b0;
  logic [31:0] addr     = '0;
  logic [31:0] wdata    = '0;
  logic [31:0] rdata;
  logic        ready;
  logic        err;

  apb_master_if #(.NUM_SLV(NSLV)) bus ();

  apb_master #(
    .NUM_SLV    (NSLV),
    .BASE_ADDR  (BASE),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .transfer(transfer),
    .write   (write),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .ready   (ready),
    .err     (err),
    .apb     (bus)
  );

  always #5 PCLK = ~PCLK;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;
  int cyc      = 0;

  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- slave models ----------------
  logic [31:0]     slv_mem [NSLV][16];
  logic [31:0]     noise_dat [NSLV];
  logic [NSLV-1:0] noise_rdy = '0;
  bit              mem_init  = 1'b0;
  int              cur_wait  = 0;
  int              acc_cnt   = 0;

  always_comb begin
    bus.PREADY = '0;
    bus.PRDATA = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (bus.PSEL[i]) begin
        bus.PREADY[i]          = bus.PENABLE && (acc_cnt >= cur_wait);
        bus.PRDATA[32*i +: 32] = slv_mem[i][bus.PADDR[5:2]];
      end else begin
        bus.PREADY[i]          = noise_rdy[i];
        bus.PRDATA[32*i +: 32] = noise_dat[i];
      end
    end
  end

  always @(posedge PCLK) begin
    noise_rdy <= NSLV'($urandom);
    for (int i = 0; i < NSLV; i++) noise_dat[i] <= $urandom;
    if (bus.PENABLE && ((bus.PSEL & bus.PREADY) == '0)) acc_cnt <= acc_cnt + 1;
    else                                                  acc_cnt <= 0;
    if (!mem_init) begin
      for (int i = 0; i < NSLV; i++)
        for (int j = 0; j < 16; j++) slv_mem[i][j] <= '0;
      mem_init <= 1'b1;
    end else begin
      for (int i = 0; i < NSLV; i++)
        if (bus.PSEL[i] && bus.PENABLE && bus.PWRITE && bus.PREADY[i])
          slv_mem[i][bus.PADDR[5:2]] <= bus.PWDATA;
    end
  end

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t            sb_q [$];
  logic [31:0]     ref_mem [NSLV][16];
  logic [NSLV-1:0] exp_psel   = '0;
  logic [31:0]     exp_paddr  = '0;
  logic [31:0]     exp_pwdata = '0;
  logic            exp_pwrite = 1'b0;
  logic [31:0]     unm_tab [6] = '{32'h0FFF_FFFC, 32'h1000_4000, 32'h1000_5000,
                                   32'h0000_0000, 32'hFFFF_F000, 32'h2000_0000};

  // Called at a negedge with the bridge idle (or in its ready cycle)
  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d, input int wt);
    exp_t e;
    logic mapped;
    int   s;
    logic [3:0] w;
    mapped  = (a >= BASE) && (((a - BASE) / 32'h1000) < 32'(NSLV));
    s       = mapped ? int'((a - BASE) / 32'h1000) : 0;
    w       = a[5:2];
    e.err   = !mapped;
    e.rdata = '0;
    e.lat   = 3;
    e.acc   = 0;
    if (mapped) begin
      if (TMO_EN && wt >= TMO) begin
        e.err = 1'b1;
        e.lat = 2 + TMO;
      end else begin
        e.lat = 3 + wt;
        if (wr) ref_mem[s][w] = d;
        else    e.rdata = ref_mem[s][w];
      end
    end
    exp_psel   = mapped ? (NSLV'(1) << s) : '0;
    exp_paddr  = a;
    exp_pwdata = d;
    exp_pwrite = wr;
    cur_wait   = wt;
    transfer   = 1'b1;
    write      = wr;
    addr       = a;
    wdata      = d;
    @(posedge PCLK);
    #1;
    e.acc = cyc;
    sb_q.push_back(e);
    @(negedge PCLK);
    transfer = 1'b0;
    write    = 1'($urandom);
    addr     = $urandom;
    wdata    = $urandom;
  endtask

  // junk: 0 none, 1 always pulse a stray request in ACCESS, 2 sometimes
  task automatic wait_ready(input int junk);
    int n;
    bit pulsed;
    n      = 0;
    pulsed = 1'b0;
    forever begin
      @(negedge PCLK);
      if (transfer) transfer = 1'b0;
      if (ready) return;
      n++;
      if (n > 2000) begin
        n_checks++;
        n_fail++;
        $display("FAIL ready_wait: no ready within 2000 cycles, required a completion");
        return;
      end
      if (junk != 0 && !pulsed && bus.PENABLE &&
          (junk == 1 || $urandom_range(0, 2) == 0)) begin
        transfer = 1'b1;
        write    = 1'($urandom);
        addr     = $urandom;
        wdata    = $urandom;
        pulsed   = 1'b1;
      end
    end
  endtask

  // Response monitor
  always @(negedge PCLK) begin
    exp_t e;
    if (!PRESET) begin
      if (ready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_ready: ready=1 with no pending request, required 0");
        end else begin
          e = sb_q.pop_front();
          check("rdata", 64'(rdata), 64'(e.rdata));
          check("err", 64'(err), 64'(e.err));
          check("latency", 64'(cyc - e.acc), 64'(e.lat));
          n_done++;
          $display("txn %0d: rdata=%08h err=%0b latency=%0d", n_done, rdata, err, cyc - e.acc);
        end
      end else begin
        check("err_without_ready", 64'(err), 64'(0));
      end
    end
  end

  // APB bus checker: whenever a slave is addressed the bus must carry the accepted request
  always @(negedge PCLK) begin
    if (!PRESET && (bus.PENABLE || (bus.PSEL != '0))) begin
      check("apb_psel_paddr_pwrite", 64'({bus.PSEL, bus.PADDR, bus.PWRITE}),
            64'({exp_psel, exp_paddr, exp_pwrite}));
      if (exp_pwrite) check("apb_pwdata", 64'(bus.PWDATA), 64'(exp_pwdata));
    end
  end

  initial begin
    int          wt;
    int          n;
    logic [31:0] a;

    for (int i = 0; i < NSLV; i++)
      for (int j = 0; j < 16; j++) ref_mem[i][j] = '0;

    PRESET = 1'b1;
    repeat (3) @(negedge PCLK);
    check("reset_psel",    64'(bus.PSEL),    64'(0));
    check("reset_penable", 64'(bus.PENABLE), 64'(0));
    check("reset_pwrite",  64'(bus.PWRITE),  64'(0));
    check("reset_paddr",   64'(bus.PADDR),   64'(0));
    check("reset_pwdata",  64'(bus.PWDATA),  64'(0));
    check("reset_ready",   64'(ready),       64'(0));
    check("reset_err",     64'(err),         64'(0));
    check("reset_rdata",   64'(rdata),       64'(0));
    PRESET = 1'b0;
    @(negedge PCLK);

    // Directed cases, including window boundaries
    issue(1'b1, 32'h1000_0008, 32'h0000_00A5, 0); wait_ready(0);
    issue(1'b1, 32'h1000_1004, 32'h0000_1234, 0); wait_ready(0);
    issue(1'b0, 32'h1000_1004, 32'h0,         1); wait_ready(0);
    issue(1'b0, 32'h1000_5000, 32'h0,         0); wait_ready(0);
    issue(1'b1, 32'h0FFF_FFFC, 32'hDEAD_0001, 0); wait_ready(0);
    issue(1'b1, 32'h1000_3FFC, 32'hBEEF_0002, 2); wait_ready(0);
    issue(1'b0, 32'h1000_3FFC, 32'h0,         0); wait_ready(0);
    issue(1'b0, 32'h1000_4000, 32'h0,         0); wait_ready(0);
    issue(1'b0, 32'h1000_0000, 32'h0,         0); wait_ready(0);

    // Stray request during ACCESS is dropped; the next one lands in the ready cycle
    issue(1'b0, 32'h1000_0008, 32'h0,         3); wait_ready(1);
    issue(1'b1, 32'h1000_2010, 32'h5A5A_5A5A, 0); wait_ready(0);
    issue(1'b0, 32'h1000_2010, 32'h0,         0); wait_ready(0);

    // Reset in the middle of ACCESS with the slave stalled
    issue(1'b0, 32'h1000_2000, 32'h0, STUCK);
    n = 0;
    while (!bus.PENABLE && n < 10) begin
      @(negedge PCLK);
      n++;
    end
    repeat (2) @(negedge PCLK);
    PRESET = 1'b1;
    #1;
    check("midreset_psel",    64'(bus.PSEL),    64'(0));
    check("midreset_penable", 64'(bus.PENABLE), 64'(0));
    check("midreset_ready",   64'(ready),       64'(0));
    sb_q.delete();
    @(negedge PCLK);
    PRESET   = 1'b0;
    cur_wait = 0;
    repeat (4) @(negedge PCLK);
    issue(1'b1, 32'h1000_0010, 32'hC0DE_0003, 0); wait_ready(0);
    issue(1'b0, 32'h1000_0010, 32'h0,         0); wait_ready(0);

`ifdef APB_TIMEOUT_EN
    issue(1'b0, 32'h1000_1000, 32'h0, STUCK); wait_ready(0);
    check("timeout_psel_dropped",    64'(bus.PSEL),    64'(0));
    check("timeout_penable_dropped", 64'(bus.PENABLE), 64'(0));
    issue(1'b1, 32'h1000_1008, 32'h0000_0077, 0); wait_ready(0);
    issue(1'b0, 32'h1000_1008, 32'h0,         0); wait_ready(0);
`endif

    // Randomized traffic: mapped/unmapped mix, wait states, gaps, back-to-back, stray requests
    for (int t = 0; t < 300; t++) begin
      wt = $urandom_range(0, 3);
      if ($urandom_range(0, 9) < 8)
        a = BASE + 32'($urandom_range(0, NSLV - 1)) * 32'h1000 + ($urandom & 32'h0000_0FFC);
      else
        a = unm_tab[$urandom_range(0, 5)];
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge PCLK);
      issue(1'($urandom_range(0, 1)), a, $urandom, wt);
      wait_ready(2);
    end

    repeat (6) @(negedge PCLK);
    check("scoreboard_drained", 64'(sb_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
